mul_frame_ctrl: RTL and testbench

Sequences the UART byte-multiplier datapath: pairs received bytes into one operand word, issues it to the multiplier, then serialises the 2W-bit product back to the transmitter, high byte first. Sits between receive, multiply and transmit in the board top. Replaces ad-hoc pack/unpack glue. Adds inter-byte timeout and receive-error resynchronisation.

---
 rtl/mul_frame_pkg.sv | 33 +++
 rtl/mul_frame_ctrl_timer.sv | 33 +++
 rtl/mul_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_mul_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_frame_pkg.sv
// Shared types and constants for the UART multiplier frame sequencer.
// Optional checksum byte: define MUL_FRAME_CTRL_CHK_EN.
package mul_frame_pkg;

  // Handshake: a transfer happens on a rising edge where stb && rdy.
  // The source holds stb and dat stable until the transfer occurs.
  // A sink may raise or drop rdy freely; rdy never waits on stb.

  localparam int FREQ        = 12_000_000;
  localparam int TIMEOUT_DEF = FREQ / 100;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_B   = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_RESULT   = 3'd3;
  localparam logic [2:0] S_SEND_HI  = 3'd4;
  localparam logic [2:0] S_SEND_LO  = 3'd5;
  localparam logic [2:0] S_SEND_CHK = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_WAIT_B  = S_WAIT_B,
    ST_ISSUE   = S_ISSUE,
    ST_RESULT  = S_RESULT,
    ST_SEND_HI = S_SEND_HI,
    ST_SEND_LO = S_SEND_LO
`ifdef MUL_FRAME_CTRL_CHK_EN
    ,
    ST_SEND_CHK = S_SEND_CHK
`endif
  } state_t;

endpackage

// File: rtl/mul_frame_ctrl_timer.sv
// frame_timer: clear/enable counter that saturates at TIMEOUT.
// TIMEOUT of 0 keeps the expiry flag permanently low.
module frame_timer
  import mul_frame_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] LIM = TW'(TIMEOUT);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && r_cnt != LIM) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT != 0) && (r_cnt == LIM);

endmodule

// File: rtl/mul_frame_ctrl.sv
// mul_frame_ctrl: pairs RX bytes into an operand, issues it, then
// serialises the product high byte first (MUL_FRAME_CTRL_CHK_EN adds XOR).
module mul_frame_ctrl
  import mul_frame_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_stb,
  input  logic [W-1:0]   s_dat,
  output logic           s_rdy,
  input  logic           s_err,
  output logic           c_stb,
  output logic [2*W-1:0] c_dat,
  input  logic           c_rdy,
  input  logic           r_stb,
  input  logic [2*W-1:0] r_dat,
  output logic           r_rdy,
  output logic           t_stb,
  output logic [W-1:0]   t_dat,
  input  logic           t_rdy,
  output logic           busy,
  output logic           drop
);

  state_t       r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_lo;
`ifdef MUL_FRAME_CTRL_CHK_EN
  logic [W-1:0] r_chk;
`endif
  logic         w_expired;
  logic         w_tclr;
  logic         w_ten;

  // Timer is held at zero outside WAIT_B, so it starts fresh per frame.
  assign w_tclr = (r_state != ST_WAIT_B);
  assign w_ten  = (r_state == ST_WAIT_B);

  frame_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tclr),
    .i_en     (w_ten),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_lo    <= '0;
`ifdef MUL_FRAME_CTRL_CHK_EN
      r_chk   <= '0;
`endif
      s_rdy   <= 1'b1;
      c_stb   <= 1'b0;
      c_dat   <= '0;
      r_rdy   <= 1'b0;
      t_stb   <= 1'b0;
      t_dat   <= '0;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_stb && !s_err) begin
            r_a     <= s_dat;
            busy    <= 1'b1;
            r_state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (s_err) begin
            drop    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (s_stb) begin
            c_dat   <= {r_a, s_dat};
            c_stb   <= 1'b1;
            s_rdy   <= 1'b0;
            r_state <= ST_ISSUE;
          end else if (w_expired) begin
            drop    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (c_rdy) begin
            c_stb   <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (r_stb) begin
            r_lo    <= r_dat[W-1:0];
`ifdef MUL_FRAME_CTRL_CHK_EN
            r_chk   <= r_dat[2*W-1:W] ^ r_dat[W-1:0];
`endif
            r_rdy   <= 1'b0;
            t_stb   <= 1'b1;
            t_dat   <= r_dat[2*W-1:W];
            r_state <= ST_SEND_HI;
          end
        end
        ST_SEND_HI: begin
          if (t_rdy) begin
            t_dat   <= r_lo;
            r_state <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (t_rdy) begin
`ifdef MUL_FRAME_CTRL_CHK_EN
            t_dat   <= r_chk;
            r_state <= ST_SEND_CHK;
`else
            t_stb   <= 1'b0;
            s_rdy   <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
`endif
          end
        end
`ifdef MUL_FRAME_CTRL_CHK_EN
        ST_SEND_CHK: begin
          if (t_rdy) begin
            t_stb   <= 1'b0;
            s_rdy   <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
`endif
        default: begin
          c_stb   <= 1'b0;
          r_rdy   <= 1'b0;
          t_stb   <= 1'b0;
          s_rdy   <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_frame_ctrl.sv
// Directed bench for mul_frame_ctrl with operand/byte scoreboards.
// Follows MUL_FRAME_CTRL_CHK_EN to expect the checksum byte.
module tb_mul_frame_ctrl;

  localparam int W  = 8;
  localparam int TO = 100;
`ifdef MUL_FRAME_CTRL_CHK_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           s_stb = 1'b0;
  logic [W-1:0]   s_dat = '0;
  logic           s_rdy;
  logic           s_err = 1'b0;
  logic           c_stb;
  logic [2*W-1:0] c_dat;
  logic           c_rdy = 1'b0;
  logic           r_stb = 1'b0;
  logic [2*W-1:0] r_dat = '0;
  logic           r_rdy;
  logic           t_stb;
  logic [W-1:0]   t_dat;
  logic           t_rdy = 1'b0;
  logic           busy;
  logic           drop;

  always #5 clk = ~clk;

  mul_frame_ctrl #(
    .W      (W),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_stb(s_stb),
    .s_dat(s_dat),
    .s_rdy(s_rdy),
    .s_err(s_err),
    .c_stb(c_stb),
    .c_dat(c_dat),
    .c_rdy(c_rdy),
    .r_stb(r_stb),
    .r_dat(r_dat),
    .r_rdy(r_rdy),
    .t_stb(t_stb),
    .t_dat(t_dat),
    .t_rdy(t_rdy),
    .busy (busy),
    .drop (drop)
  );

  logic [2*W-1:0] q_op[$];
  logic [W-1:0]   q_tx[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [W-1:0] d);
    s_stb = 1'b1;
    s_dat = d;
    for (int i = 0; i < 100 && !s_rdy; i++) tick();
    chk("s_rdy_wait", {31'd0, s_rdy}, 1);
    tick();
    s_stb = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] a,
                            input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = a * b;
    q_op.push_back({a, b});
    q_tx.push_back(p[2*W-1:W]);
    q_tx.push_back(p[W-1:0]);
`ifdef MUL_FRAME_CTRL_CHK_EN
    q_tx.push_back(p[2*W-1:W] ^ p[W-1:0]);
`endif
    send_byte(a);
    send_byte(b);
  endtask

  task automatic serve_op(input int hold);
    logic [2*W-1:0] op, cap, p;
    bit bad;
    for (int i = 0; i < 100 && !c_stb; i++) tick();
    chk("c_stb_wait", {31'd0, c_stb}, 1);
    op = 'x;
    if (q_op.size() != 0) op = q_op.pop_front();
    chk("c_dat", {16'd0, c_dat}, {16'd0, op});
    cap = c_dat;
    bad = 1'b0;
    repeat (hold) begin
      tick();
      if (c_stb !== 1'b1 || c_dat !== cap) bad = 1'b1;
    end
    chk("c_hold", {31'd0, bad}, 0);
    c_rdy = 1'b1;
    tick();
    c_rdy = 1'b0;
    chk("c_stb_low", {31'd0, c_stb}, 0);
    for (int i = 0; i < 100 && !r_rdy; i++) tick();
    chk("r_rdy_wait", {31'd0, r_rdy}, 1);
    p = cap[2*W-1:W] * cap[W-1:0];
    r_stb = 1'b1;
    r_dat = p;
    tick();
    r_stb = 1'b0;
    r_dat = '0;
  endtask

  task automatic recv(input int hold);
    logic [W-1:0] exp, cap;
    bit bad;
    for (int i = 0; i < 100 && !t_stb; i++) tick();
    chk("t_stb_wait", {31'd0, t_stb}, 1);
    exp = 'x;
    if (q_tx.size() != 0) exp = q_tx.pop_front();
    cap = t_dat;
    bad = 1'b0;
    repeat (hold) begin
      tick();
      if (t_stb !== 1'b1 || t_dat !== cap) bad = 1'b1;
    end
    chk("t_hold", {31'd0, bad}, 0);
    chk("t_dat", {24'd0, cap}, {24'd0, exp});
    t_rdy = 1'b1;
    tick();
    t_rdy = 1'b0;
  endtask

  task automatic recv_frame(input int hold);
    repeat (NB) recv(hold);
    chk("busy_end", {31'd0, busy}, 0);
    chk("t_stb_end", {31'd0, t_stb}, 0);
    chk("q_tx_left", q_tx.size(), 0);
  endtask

  initial begin
    int  cyc;
    bit  bad;
    tick(3);
    chk("rst_s_rdy", {31'd0, s_rdy}, 1);
    chk("rst_c_stb", {31'd0, c_stb}, 0);
    chk("rst_r_rdy", {31'd0, r_rdy}, 0);
    chk("rst_t_stb", {31'd0, t_stb}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_drop", {31'd0, drop}, 0);
    chk("rst_c_dat", {16'd0, c_dat}, 0);
    chk("rst_t_dat", {24'd0, t_dat}, 0);
    rst = 1'b1;
    tick(2);

    // basic frame
    send_frame(8'h03, 8'h05);
    chk("busy_mid", {31'd0, busy}, 1);
    serve_op(0);
    recv_frame(0);

    // backpressure on operand and bytes
    send_frame(8'h03, 8'h05);
    serve_op(7);
    recv_frame(10);

    // receive error in IDLE: byte discarded
    s_err = 1'b1;
    s_stb = 1'b1;
    s_dat = 8'h77;
    tick();
    s_err = 1'b0;
    s_stb = 1'b0;
    chk("err_idle_busy", {31'd0, busy}, 0);
    chk("err_idle_drop", {31'd0, drop}, 0);

    // inter-byte timeout
    send_byte(8'h11);
    cyc = 0;
    while (!drop && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("to_drop", {31'd0, drop}, 1);
    chk("to_window", {31'd0, (cyc >= TO && cyc <= TO + 2)}, 1);
    chk("to_busy", {31'd0, busy}, 0);
    tick();
    chk("to_pulse", {31'd0, drop}, 0);
    chk("to_c_stb", {31'd0, c_stb}, 0);
    send_frame(8'h02, 8'h07);
    serve_op(2);
    recv_frame(1);

    // receive error in WAIT_B, with a byte in the same cycle
    send_byte(8'h44);
    s_err = 1'b1;
    s_stb = 1'b1;
    s_dat = 8'h55;
    tick();
    s_err = 1'b0;
    s_stb = 1'b0;
    chk("err_drop", {31'd0, drop}, 1);
    chk("err_busy", {31'd0, busy}, 0);
    chk("err_c_stb", {31'd0, c_stb}, 0);
    tick();
    chk("err_pulse", {31'd0, drop}, 0);
    chk("err_no_c", {31'd0, c_stb}, 0);
    send_frame(8'h09, 8'h09);
    serve_op(0);
    recv_frame(0);

    // async reset while sending the low byte
    send_frame(8'h03, 8'h05);
    serve_op(0);
    recv(0);
    chk("pre_rst_t_stb", {31'd0, t_stb}, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_t_stb", {31'd0, t_stb}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_s_rdy", {31'd0, s_rdy}, 1);
    q_tx.delete();
    tick(2);
    rst = 1'b1;
    tick();
    send_frame(8'h01, 8'h01);
    serve_op(0);
    recv_frame(0);
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (t_stb !== 1'b0) bad = 1'b1;
    end
    chk("no_extra_tx", {31'd0, bad}, 0);

    // full-scale operands
    send_frame(8'hFF, 8'hFF);
    serve_op(1);
    recv_frame(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
